// File: rtl/deserializer_sipo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | deserializer_sipo : LSB-first serial-in/parallel-out word assembler      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module deserializer_sipo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  bit_en,
  input  logic                  frame_start,
  input  logic                  frame_stop,
  input  logic                  data_ready,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;

  logic                  accept;
  logic                  word_done;
  logic                  out_free;
  logic                  ovr_evt;
  logic                  ferr_evt;
  logic [CNT_W-1:0]      cnt_base;
  logic [CNT_W-1:0]      cnt_inc;
  logic [CNT_W-1:0]      cnt_after;
  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ovr_evt   = 1'b0;
    ferr_evt  = 1'b0;

    // frame_start realigns the counter, so a same-cycle strobe lands as bit 0
    accept    = bit_en && ((state_q == RECV) || frame_start);
    cnt_base  = frame_start ? '0 : cnt_q;
    cnt_inc   = (cnt_base == LAST_IDX) ? '0 : cnt_base + CNT_W'(1);
    cnt_after = accept ? cnt_inc : cnt_base;
    word      = {srl_in, shreg_q[DATA_WIDTH-1:1]};
    word_done = accept && (cnt_base == LAST_IDX);
    out_free  = !valid_q || data_ready;

    if (accept) begin
      shreg_d = word;
    end

    if (frame_start) begin
      state_d  = RECV;
      cnt_d    = cnt_after;
      ferr_evt = frame_stop && (state_q == RECV) && (cnt_q != '0);
    end else if (state_q == RECV) begin
      if (frame_stop) begin
        state_d  = IDLE;
        cnt_d    = '0;
        ferr_evt = (cnt_after != '0);
      end else begin
        cnt_d = cnt_after;
      end
    end

    if (word_done) begin
      if (out_free) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_evt = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    // a fresh error event beats a simultaneous clear
    ovr_d  = (ovr_q && !clr_err) || ovr_evt;
    ferr_d = (ferr_q && !clr_err) || ferr_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == RECV);
  assign overrun    = ovr_q;
  assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: doc/deserializer_sipo.md
DESERIALIZER_SIPO -- requirements
Module: deserializer_sipo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port srl_in, input, 1 bit: serial data, LSB first, sampled only when bit_en=1.
REQ-005 The block SHALL have port bit_en, input, 1 bit: bit strobe; one accepted bit per clk cycle with bit_en=1.
REQ-006 The block SHALL have port frame_start, input, 1 bit: single-cycle pulse that opens a frame and aligns the bit counter.
REQ-007 The block SHALL have port frame_stop, input, 1 bit: single-cycle pulse that closes the current frame.
REQ-008 The block SHALL have port data_ready, input, 1 bit: the consumer accepts data_out.
REQ-009 The block SHALL have port clr_err, input, 1 bit: clears the sticky error flags.
REQ-010 The block SHALL have port data_out, output, DATA_WIDTH bits: the assembled parallel word.
REQ-011 The block SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed word.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in state RECV.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag set when a completed word is dropped.
REQ-014 The block SHALL have port frame_err, output, 1 bit: sticky flag set when a frame closes with a partial word.

Function
REQ-015 The FSM SHALL have two states, IDLE and RECV; busy SHALL equal (state==RECV).
REQ-016 In IDLE, bit_en SHALL be ignored and the shift register and bit counter SHALL hold their values.
REQ-017 A frame_start pulse SHALL move the FSM to RECV from any state, clear the bit counter, and discard any partial word.
REQ-018 If bit_en=1 in the same cycle as frame_start, that bit SHALL be accepted as bit 0 of the new word.
REQ-019 In RECV, each bit_en=1 cycle SHALL shift srl_in into the MSB of the shift register, shift right by one, and increment the counter; the first bit received SHALL end up in data_out[0].
REQ-020 The counter SHALL be $clog2(DATA_WIDTH) bits wide, SHALL wrap to 0 on the DATA_WIDTH-th accepted bit, and the word SHALL then be complete.
REQ-021 On word completion, the FSM SHALL stay in RECV for the next word, giving continuous streaming with no gap cycle.
REQ-022 When a word completes and the output register is free, the complete word SHALL load into data_out and data_valid SHALL be 1 in the cycle after the last bit's strobe cycle (latency 1 clk).
REQ-023 The output register SHALL be free when data_valid=0, or when data_valid=1 and data_ready=1 in the same cycle.
REQ-024 data_valid SHALL clear on data_valid=1 and data_ready=1 when no new word completes in that cycle; data_out SHALL hold its value until it is reloaded.
REQ-025 If a word completes while data_valid=1 and data_ready=0, the new word SHALL be dropped, data_out SHALL keep the old word, and overrun SHALL be set.
REQ-026 A frame_stop pulse in RECV SHALL return the FSM to IDLE and clear the counter.
REQ-027 If frame_stop arrives with counter≠0, the partial word SHALL be discarded and frame_err SHALL be set.
REQ-028 If frame_stop arrives in the same cycle as the bit that completes a word, the word SHALL be delivered as normal and frame_err SHALL NOT be set.
REQ-029 If frame_start and frame_stop are both high, frame_start SHALL win: the FSM enters RECV, and frame_err is still set if a partial word was pending.
REQ-030 frame_stop in IDLE SHALL have no effect.
REQ-031 clr_err SHALL clear overrun and frame_err; if a new error event occurs in the same cycle, the set SHALL win.
REQ-032 data_ready while data_valid=0 SHALL have no effect.

Reset
REQ-033 When rst=1 at a clk edge, the block SHALL set state=IDLE, counter=0, shift register=0, data_out=0, data_valid=0, busy=0, overrun=0 and frame_err=0, regardless of all other inputs.
REQ-034 A reset in mid-word SHALL discard the partial word, and no data_valid pulse SHALL follow it.

Verification
REQ-035 Single word: DATA_WIDTH=8, frame_start with bit 0, bits 1,0,1,0,0,1,0,1 with bit_en=1 each cycle -> data_out=8'hA5, and data_valid=1 one cycle after the 8th bit.
REQ-036 Back-to-back stream: send 0x3C then 0xC3 continuously with data_ready=1 -> two valid words 0x3C then 0xC3, overrun=0, busy=1 throughout.
REQ-037 Overrun: deliver 0x11, hold data_ready=0, send 0x22 -> data_out stays 0x11 and overrun=1; then pulse clr_err -> overrun=0.
REQ-038 Partial frame: send 5 bits then frame_stop -> FSM goes to IDLE, frame_err=1, data_valid stays 0; then frame_start and a full 0x5A -> data_out=0x5A.
REQ-039 Gapped strobes and realign: bit_en toggling 1/0, frame_start mid-word after 3 bits -> counter restarts and the next 8 accepted bits form data_out.
REQ-040 Reset mid-word: rst after 4 bits -> all outputs 0; with no frame_start afterwards, bit_en in IDLE produces no data_valid.
